// File: rtl/audio_frame_sequencer_if.sv
// Bundles the FIFO read port, the frame RAM write port and the consumer
// handshake of audio_frame_sequencer. master = sequencer side, slave = surroundings.
interface audio_frame_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    // Handshakes: fifo_rdreq pulls one word per cycle; fifo_q carries it on the
    // next cycle. frame_ready/frame_bank stay asserted until the consumer pulses
    // frame_ack for one cycle while frame_ready is high; acks without an offered
    // frame are ignored and the offer is never withdrawn by the sequencer.
    logic              enable;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_rdempty;
    logic              fifo_rdreq;
    logic              buf_we;
    logic [ADDR_W:0]   buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic              frame_ready;
    logic              frame_bank;
    logic              frame_ack;
    logic [15:0]       frames_dropped;
    logic              overrun;

    modport master (
        input  enable, fifo_q, fifo_rdempty, frame_ack,
        output fifo_rdreq, buf_we, buf_addr, buf_wdata,
               frame_ready, frame_bank, frames_dropped, overrun
    );

    modport slave (
        output enable, fifo_q, fifo_rdempty, frame_ack,
        input  fifo_rdreq, buf_we, buf_addr, buf_wdata,
               frame_ready, frame_bank, frames_dropped, overrun
    );
endinterface

// File: rtl/audio_frame_sequencer.sv
// Ping-pong frame sequencer: drains the audio FIFO into two frame banks and offers
// completed banks to one consumer. Define FRAME_DROP_EN to drop frames instead of stalling.
module audio_frame_sequencer #(
    parameter int FRAME_LEN = 256,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic                   CLK,
    input  logic                   reset,
    audio_frame_sequencer_if.master bus,
    output logic [1:0]             dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    state_t            state, next_state;
    logic              fill_bank;
    logic [ADDR_W-1:0] idx;
    logic              rd_pend;
    logic              offered;
    logic              pending;
    logic              frame_bank;
    logic              rdreq;
    logic              last;
    logic              ack_eff;
    logic              take_frame;
    logic              stall_evt;

    assign last       = rd_pend && (idx == LAST_IDX);
    assign ack_eff    = bus.frame_ack && offered;
    // An ack in the completing cycle frees the slot, so the new frame is offered directly.
    assign take_frame = last && (!offered || (ack_eff && !pending));
`ifdef FRAME_DROP_EN
    assign stall_evt  = 1'b0;
`else
    assign stall_evt  = last && !take_frame;
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.enable) next_state = FILL;
            FILL:    if (!bus.enable) next_state = IDLE;
            HOLD:    if (ack_eff && pending) next_state = bus.enable ? FILL : IDLE;
            default: next_state = IDLE;
        endcase
        if (stall_evt) next_state = HOLD;
    end

    // No read is issued in the cycle that stalls, otherwise its word would land in the offered bank.
    always_comb begin
        rdreq = 1'b0;
        if (state == FILL && bus.enable && !bus.fifo_rdempty && !stall_evt) rdreq = 1'b1;
    end

    assign bus.fifo_rdreq  = rdreq;
    assign bus.buf_we      = rd_pend;
    assign bus.buf_addr    = {fill_bank, idx};
    assign bus.buf_wdata   = rd_pend ? bus.fifo_q : '0;
    assign bus.frame_ready = offered;
    assign bus.frame_bank  = frame_bank;
    assign dbg_state       = state;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fill_bank  <= 1'b0;
            idx        <= '0;
            rd_pend    <= 1'b0;
            offered    <= 1'b0;
            pending    <= 1'b0;
            frame_bank <= 1'b0;
        end else begin
            rd_pend <= rdreq;
            if (ack_eff) begin
                if (pending) begin
                    frame_bank <= ~frame_bank;
                    pending    <= 1'b0;
                end else begin
                    offered <= 1'b0;
                end
            end
            if (rd_pend) begin
                if (idx == LAST_IDX) begin
                    idx <= '0;
                    if (take_frame) begin
                        offered    <= 1'b1;
                        frame_bank <= fill_bank;
                        fill_bank  <= ~fill_bank;
                    end
`ifndef FRAME_DROP_EN
                    else begin
                        pending   <= 1'b1;
                        fill_bank <= ~fill_bank;
                    end
`endif
                end else begin
                    idx <= bus.enable ? idx + ADDR_W'(1) : '0;
                end
            end else if (!bus.enable) begin
                idx <= '0;
            end
        end
    end

`ifdef FRAME_DROP_EN
    logic [15:0] dropped;
    logic        overrun_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            dropped   <= '0;
            overrun_q <= 1'b0;
        end else if (last && !take_frame) begin
            if (dropped != 16'hFFFF) dropped <= dropped + 16'd1;
            overrun_q <= 1'b1;
        end
    end

    assign bus.frames_dropped = dropped;
    assign bus.overrun        = overrun_q;
`else
    assign bus.frames_dropped = '0;
    assign bus.overrun        = 1'b0;
`endif
endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed bench for audio_frame_sequencer at FRAME_LEN=8 with a FIFO model
// and a write scoreboard; define FRAME_DROP_EN to exercise the drop variant.
`timescale 1ns/1ps
module tb_audio_frame_sequencer;
    localparam int FRAME_LEN = 8;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 3;
    localparam int W         = ADDR_W + 1 + DATA_W;

    logic       CLK = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    audio_frame_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    audio_frame_sequencer #(.FRAME_LEN(FRAME_LEN), .DATA_W(DATA_W)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    // FIFO model: normal mode, data valid the cycle after the read request.
    logic [DATA_W-1:0] mem [0:255];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic gate = 1'b0;
    logic rdreq_at_edge = 1'b0;

    assign bus.fifo_rdempty = (wr_ptr == rd_ptr) || gate;

    always @(posedge CLK) begin
        rdreq_at_edge <= bus.fifo_rdreq;
        if (bus.fifo_rdreq === 1'b1) begin
            bus.fifo_q <= mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    logic [W-1:0] exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_we_cyc = 0;
    int   first_we_cyc = -1;
    logic toggle_en = 1'b0;
    logic tb_bank = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [W-1:0] e;
        @(negedge CLK);
        cyc++;
        if (toggle_en) check("we_after_rdreq", 64'(bus.buf_we), 64'(rdreq_at_edge));
        if (bus.buf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 64'(bus.buf_we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("write", 64'({bus.buf_addr, bus.buf_wdata}), 64'(e));
                last_we_cyc = cyc;
                if (first_we_cyc < 0) first_we_cyc = cyc;
            end
        end
        if (toggle_en) gate = ~gate;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.frame_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.frame_ready), 64'd1);
    endtask

    task automatic wait_drain(input string tag, input int target);
        int n = 0;
        while (exp_q.size() > target && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'(target));
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
    endtask

    task automatic push_fifo(input logic [DATA_W-1:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr++;
    endtask

    task automatic push_exp(input logic bank, input int i, input logic [DATA_W-1:0] d);
        exp_q.push_back({bank, i[ADDR_W-1:0], d});
    endtask

    task automatic push_frame(input logic bank, input logic [DATA_W-1:0] base);
        for (int i = 0; i < FRAME_LEN; i++) begin
            push_exp(bank, i, base + DATA_W'(i));
            push_fifo(base + DATA_W'(i));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.frame_ack = 1'b0;
        tick();
        tick();
        check("reset_we",      64'(bus.buf_we),         64'd0);
        check("reset_rdreq",   64'(bus.fifo_rdreq),     64'd0);
        check("reset_addr",    64'(bus.buf_addr),       64'd0);
        check("reset_wdata",   64'(bus.buf_wdata),      64'd0);
        check("reset_ready",   64'(bus.frame_ready),    64'd0);
        check("reset_bank",    64'(bus.frame_bank),     64'd0);
        check("reset_dropped", 64'(bus.frames_dropped), 64'd0);
        check("reset_overrun", 64'(bus.overrun),        64'd0);
        check("reset_state",   64'(dbg_state),          64'd0);

        // First frame: 0x10..0x17 into bank 0 at full rate.
        push_frame(1'b0, 32'h10);
        reset = 1'b0;
        bus.enable = 1'b1;
        first_we_cyc = -1;
        wait_ready("t1_ready");
        check("t1_ready_latency", 64'(cyc - last_we_cyc), 64'd1);
        check("t1_burst_len", 64'(last_we_cyc - first_we_cyc), 64'(FRAME_LEN - 1));
        check("t1_bank", 64'(bus.frame_bank), 64'd0);
        check("t1_drained", 64'(exp_q.size()), 64'd0);
        ack();
        check("t1_release", 64'(bus.frame_ready), 64'd0);
        tb_bank = 1'b1;

`ifndef FRAME_DROP_EN
        // Fill bank 1 (offered), bank 0 (stalls in HOLD), then bank 1 again after ack.
        push_frame(1'b1, 32'h20);
        push_frame(1'b0, 32'h28);
        push_frame(1'b1, 32'h30);
        wait_ready("t2_ready_b1");
        check("t2_bank1", 64'(bus.frame_bank), 64'd1);
        wait_drain("t2_bank0_written", 8);
        repeat (3) tick();
        check("t2_hold_rdreq", 64'(bus.fifo_rdreq), 64'd0);
        check("t2_hold_state", 64'(dbg_state), 64'd2);
        check("t2_hold_no_write", 64'(exp_q.size()), 64'd8);
        check("t2_hold_bank", 64'(bus.frame_bank), 64'd1);
        ack();
        check("t2_swap_bank", 64'(bus.frame_bank), 64'd0);
        check("t2_swap_ready", 64'(bus.frame_ready), 64'd1);
        check("t2_resume_rdreq", 64'(bus.fifo_rdreq), 64'd1);
        wait_drain("t2_bank1_rewritten", 0);
        repeat (3) tick();
        check("t2_hold2_state", 64'(dbg_state), 64'd2);
        check("t2_hold2_bank", 64'(bus.frame_bank), 64'd0);
        ack();
        check("t2_swap2_bank", 64'(bus.frame_bank), 64'd1);
        ack();
        check("t2_release", 64'(bus.frame_ready), 64'd0);
        tb_bank = 1'b0;
`endif

        // FIFO empty flag toggling every cycle.
        push_frame(tb_bank, 32'h40);
        toggle_en = 1'b1;
        wait_ready("t3_ready");
        toggle_en = 1'b0;
        gate = 1'b0;
        check("t3_bank", 64'(bus.frame_bank), 64'(tb_bank));
        check("t3_drained", 64'(exp_q.size()), 64'd0);
        ack();
        tb_bank = ~tb_bank;

        // Enable drops right after the third write; the partial frame is discarded.
        for (int i = 0; i < 3; i++) push_exp(tb_bank, i, DATA_W'(32'h50 + i));
        for (int i = 0; i < 8; i++) push_fifo(DATA_W'(32'h50 + i));
        wait_drain("t4_three_writes", 0);
        bus.enable = 1'b0;
        repeat (4) begin
            tick();
            check("t4_no_rdreq", 64'(bus.fifo_rdreq), 64'd0);
        end
        check("t4_idle", 64'(dbg_state), 64'd0);
        for (int i = 0; i < 8; i++) begin
            push_exp(tb_bank, i, DATA_W'(32'h53 + i));
            if (i >= 5) push_fifo(DATA_W'(32'h53 + i));
        end
        bus.enable = 1'b1;
        wait_ready("t4_ready");
        check("t4_bank", 64'(bus.frame_bank), 64'(tb_bank));
        check("t4_drained", 64'(exp_q.size()), 64'd0);
        ack();
        tb_bank = ~tb_bank;

        // Reset in the middle of a frame while a frame is offered.
        push_frame(tb_bank, 32'h60);
        for (int i = 0; i < 3; i++) begin
            push_exp(~tb_bank, i, DATA_W'(32'h70 + i));
            push_fifo(DATA_W'(32'h70 + i));
        end
        wait_drain("t5_partial", 0);
        check("t5_ready_before_reset", 64'(bus.frame_ready), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_ready", 64'(bus.frame_ready), 64'd0);
        check("t5_rst_bank",  64'(bus.frame_bank),  64'd0);
        check("t5_rst_we",    64'(bus.buf_we),      64'd0);
        check("t5_rst_addr",  64'(bus.buf_addr),    64'd0);
        check("t5_rst_wdata", 64'(bus.buf_wdata),   64'd0);
        check("t5_rst_rdreq", 64'(bus.fifo_rdreq),  64'd0);
        check("t5_rst_state", 64'(dbg_state),       64'd0);
        tick();
        reset = 1'b0;
        tb_bank = 1'b0;
        push_frame(1'b0, 32'h80);
        wait_ready("t5_restart_ready");
        check("t5_restart_bank", 64'(bus.frame_bank), 64'd0);
        check("t5_restart_drained", 64'(exp_q.size()), 64'd0);

`ifdef FRAME_DROP_EN
        // Frame 0 stays offered; four more frames overwrite bank 1 and are dropped.
        for (int f = 0; f < 4; f++) push_frame(1'b1, DATA_W'(32'h90 + 8 * f));
        wait_drain("t6_drained", 0);
        repeat (2) tick();
        check("t6_dropped", 64'(bus.frames_dropped), 64'd4);
        check("t6_overrun", 64'(bus.overrun), 64'd1);
        check("t6_ready", 64'(bus.frame_ready), 64'd1);
        check("t6_bank", 64'(bus.frame_bank), 64'd0);
`else
        check("t6_dropped_tied", 64'(bus.frames_dropped), 64'd0);
        check("t6_overrun_tied", 64'(bus.overrun), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_frame_sequencer.md
# audio_frame_sequencer

Controller that drains the audio sample FIFO read port in the CLK domain and sequences samples into a two-bank (ping-pong) frame buffer of FRAME_LEN words. It hands each completed bank to a single consumer (Nios II PIO or visualizer datapath) through a ready/ack handshake, and arbitrates bank ownership between writer and consumer. It sits between the dual-clock FIFO read side and the frame RAM feeding display and analysis.

## Interface
Parameters:
- FRAME_LEN, 256, samples per frame; power of two, 4..4096
- DATA_W, 32, sample width (matches FIFO q)
- ADDR_W, $clog2(FRAME_LEN), derived; do not override

Ports:
- CLK  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high
- enable  in  1  capture enable, level
- fifo_q  in  DATA_W  FIFO read data; valid the cycle after fifo_rdreq (normal, non-show-ahead mode)
- fifo_rdempty  in  1  FIFO read-side empty
- fifo_rdreq  out  1  FIFO read request
- buf_we  out  1  frame RAM write enable
- buf_addr  out  ADDR_W+1  {bank, index}
- buf_wdata  out  DATA_W  frame RAM write data
- frame_ready  out  1  a completed bank is offered to the consumer
- frame_bank  out  1  bank offered; valid while frame_ready
- frame_ack  in  1  consumer releases the offered bank
- frames_dropped  out  16  dropped-frame count, saturating
- overrun  out  1  sticky, set on the first dropped frame

## Operation
- State: fill_bank (bank being written), idx (0..FRAME_LEN-1), rd_pend (read issued last cycle), offered (frame_ready), pending (second completed bank waiting).
- FSM states:
  - IDLE: entered after reset or when enable is low; no reads.
  - FILL: issue reads.
  - HOLD: both banks are full, with one offered and one pending.
- fifo_rdreq = (state==FILL) & enable & !fifo_rdempty. It is combinational from registered state and inputs.
- rd_pend=1 → next cycle:
  - buf_we=1
  - buf_wdata=fifo_q
  - buf_addr={fill_bank, idx}
  - idx increments
- Write at idx==FRAME_LEN-1 completes the frame. idx wraps to 0 and fill_bank toggles.
  - No frame offered: offered←1, frame_bank←completed bank.
  - Frame already offered, no drop: pending←1, FSM→HOLD. fifo_rdreq stays low, no further writes. Samples back up in the FIFO.
- frame_ack sampled high while offered:
  - No pending: offered←0 next cycle.
  - Pending: offered stays 1, frame_bank←other bank, pending←0, FSM→FILL. The writer resumes into the released bank.
- frame_ack while !offered is ignored. Ack and frame completion in the same cycle: the ack is processed first. The new frame is then offered with no HOLD entry.
- enable falling mid-frame: no new reads. An outstanding rd_pend write still completes. The partial frame is discarded and idx←0. The offered/pending state is untouched. FSM→IDLE, and →FILL when enable rises and state is not HOLD.

## Timing
- Reset values: all outputs 0, fill_bank=0, idx=0, state IDLE.
- fifo_rdreq at cycle t → buf_we at t+1. Sustained throughput is 1 sample/cycle while FIFO is non-empty.
- Last write at cycle t → frame_ready=1 at t+1.
- frame_ack at t → frame_ready low at t+1 (no pending), or frame_bank switches at t+1 (pending).
- HOLD → first new fifo_rdreq at t+1 after the ack cycle t.
- Reset mid-frame clears all state immediately. Buffer contents are undefined to the consumer.

## Configuration
- FRAME_DROP_EN defined:
  - HOLD is never entered.
  - When a frame completes while one is offered, the completed frame is dropped. frames_dropped increments (saturates at 0xFFFF) and overrun←1.
  - fill_bank does not toggle; the writer refills the same bank from idx 0, and reading continues uninterrupted.
- Not defined:
  - Stall behaviour as above.
  - frames_dropped and overrun are tied to 0.

## Test plan
- FRAME_LEN=8, FIFO holds 8 samples 0x10..0x17, enable=1 → 8 consecutive buf_we to addr 0..7 with data 0x10..0x17. frame_ready=1, frame_bank=0 the cycle after the last write.
- Ack frame 0, stream 16 more samples, never ack → bank 1 is filled and offered. Bank 0 is filled next; at its completion, rdreq drops and HOLD is entered. Ack → frame_bank=0 next cycle, and reads resume into bank 1.
- fifo_rdempty toggling every other cycle → buf_we only after granted reads, indices contiguous, no duplicate or skipped samples.
- enable low after 3 of 8 writes → one trailing write (if rd_pend), then no reads. Re-enable → writes restart at {fill_bank, 0}.
- FRAME_DROP_EN, never ack, 40 samples at FRAME_LEN=8:
  - Frame 0 stays offered.
  - Bank 1 is overwritten repeatedly.
  - frames_dropped=4 and overrun=1.
- Assert reset mid-frame with frame_ready high → all outputs 0 immediately. Capture restarts at bank 0, idx 0 after release.
